// File: rtl/lsu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsu_pkg : shared funct3 codes, FSM states and size decode for lsu_mem_align |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ACC0 = 3'd1,
    S_ACC1 = 3'd2,
    S_WAIT = 3'd3,
    S_RESP = 3'd4
  } lsu_state_e;

  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Access size in bytes (1, 2 or 4); only meaningful for legal funct3.
  function automatic logic [2:0] f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] size_mask(input logic [2:0] size);
    case (size)
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_mem_align_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsu_mem_align_if : MEM-stage request/response and data-memory port bundle  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface lsu_mem_align_if #(
  parameter int DM_AW = 10
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [2:0]       req_funct3;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic             resp_err;
  logic             dm_en;
  logic             dm_we;
  logic [3:0]       dm_be;
  logic [DM_AW-1:0] dm_addr;
  logic [31:0]      dm_wdata;
  logic [31:0]      dm_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, dm_rdata,
    output req_ready, resp_valid, resp_data, resp_err,
           dm_en, dm_we, dm_be, dm_addr, dm_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, dm_rdata,
    input  req_ready, resp_valid, resp_data, resp_err,
           dm_en, dm_we, dm_be, dm_addr, dm_wdata
  );
endinterface
`default_nettype wire

// File: rtl/lsu_load_extract.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsu_load_extract : shift two DM words down by the byte offset and extend   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module lsu_load_extract
  import lsu_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  input  logic [63:0] data_i,
  output logic [31:0] result_o
);

  logic [31:0] shifted;

  assign shifted = 32'(data_i >> {off_i, 3'b000});

  always_comb begin
    result_o = '0;
    case (funct3_i)
      F3_B:    result_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    result_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    result_o = shifted;
      F3_BU:   result_o = {24'h0, shifted[7:0]};
      F3_HU:   result_o = {16'h0, shifted[15:0]};
      default: result_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsu_mem_align : RV32I load/store alignment, word-crossing split, extension |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module lsu_mem_align
  import lsu_pkg::*;
#(
  parameter int DM_AW            = 10,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  lsu_mem_align_if.slave lsu
);

  lsu_state_e       state_q, state_d;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic [DM_AW-1:0] waddr_q;
  logic [31:0]      wdata_q;
  logic             split_q;
  logic             err_q;
  logic [31:0]      lo_q;
  logic [31:0]      hi_q;

  logic [2:0]       req_size;
  logic             req_split;
  logic             req_bad;
  logic             accept;
  logic [2:0]       size_q;
  logic [7:0]       be_all;
  logic [63:0]      wd_all;
  logic [31:0]      load_res;
  logic             unused_addr_hi;

  logic             req_ready;
  logic             resp_valid;
  logic             dm_en;
  logic             dm_we;
  logic [3:0]       dm_be;
  logic [DM_AW-1:0] dm_addr;
  logic [31:0]      dm_wdata;

  assign unused_addr_hi = ^lsu.req_addr[31:DM_AW+2];

  // A request crosses a word boundary when offset + size spills past lane 3.
  assign req_size  = f3_size(lsu.req_funct3);
  assign req_split = ({1'b0, lsu.req_addr[1:0]} + req_size) > 3'd4;
  assign req_bad   = !f3_legal(lsu.req_funct3) || (req_split && !ALLOW_MISALIGNED);

  assign size_q = f3_size(f3_q);
  assign be_all = {4'b0000, size_mask(size_q)} << off_q;
  assign wd_all = {32'h0, wdata_q} << {off_q, 3'b000};

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    dm_en      = 1'b0;
    dm_we      = 1'b0;
    dm_be      = '0;
    dm_addr    = '0;
    dm_wdata   = '0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (lsu.req_valid) begin
          accept  = 1'b1;
          state_d = req_bad ? S_RESP : S_ACC0;
        end
      end
      S_ACC0: begin
        dm_en    = 1'b1;
        dm_we    = we_q;
        dm_be    = be_all[3:0];
        dm_addr  = waddr_q;
        dm_wdata = wd_all[31:0];
        state_d  = split_q ? S_ACC1 : S_WAIT;
      end
      S_ACC1: begin
        dm_en    = 1'b1;
        dm_we    = we_q;
        dm_be    = be_all[7:4];
        dm_addr  = waddr_q + {{(DM_AW-1){1'b0}}, 1'b1};
        dm_wdata = wd_all[63:32];
        state_d  = S_WAIT;
      end
      S_WAIT: state_d = S_RESP;
      S_RESP: begin
        resp_valid = 1'b1;
        if (lsu.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch and read-data capture; the first DM word lands in lo_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      split_q <= 1'b0;
      err_q   <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else if (accept) begin
      we_q    <= lsu.req_we;
      f3_q    <= lsu.req_funct3;
      off_q   <= lsu.req_addr[1:0];
      waddr_q <= lsu.req_addr[DM_AW+1:2];
      wdata_q <= lsu.req_wdata;
      split_q <= req_split && !req_bad;
      err_q   <= req_bad;
      lo_q    <= '0;
      hi_q    <= '0;
    end else if (!we_q) begin
      if (state_q == S_ACC1) begin
        lo_q <= lsu.dm_rdata;
      end else if (state_q == S_WAIT) begin
        if (split_q) hi_q <= lsu.dm_rdata;
        else         lo_q <= lsu.dm_rdata;
      end
    end
  end

  lsu_load_extract u_extract (
    .off_i    (off_q),
    .funct3_i (f3_q),
    .data_i   ({hi_q, lo_q}),
    .result_o (load_res)
  );

  assign lsu.req_ready  = req_ready;
  assign lsu.resp_valid = resp_valid;
  assign lsu.resp_data  = (resp_valid && !err_q && !we_q) ? load_res : 32'h0;
  assign lsu.resp_err   = resp_valid && err_q;
  assign lsu.dm_en      = dm_en;
  assign lsu.dm_we      = dm_we;
  assign lsu.dm_be      = dm_be;
  assign lsu.dm_addr    = dm_addr;
  assign lsu.dm_wdata   = dm_wdata;

endmodule
`default_nettype wire
